// File: rtl/issue_ctrl_pkg.sv
// Shared decode constants and issue-controller state encodings.
// Imported by the decoder and the issue controller.
package issue_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ALUI   = 7'b0010011;
  localparam logic [6:0] OPC_ALU    = 7'b0110011;

  // Class bases; the low three bits carry funct3 for the classes that have one.
  localparam logic [5:0] OPTYPE_NOP      = 6'h00;
  localparam logic [5:0] OPTYPE_LUI      = 6'h01;
  localparam logic [5:0] OPTYPE_AUIPC    = 6'h02;
  localparam logic [5:0] OPTYPE_JAL      = 6'h03;
  localparam logic [5:0] OPTYPE_JALR     = 6'h04;
  localparam logic [5:0] OPTYPE_BRANCH   = 6'h08;
  localparam logic [5:0] OPTYPE_LOAD     = 6'h10;
  localparam logic [5:0] OPTYPE_STORE    = 6'h18;
  localparam logic [5:0] OPTYPE_ALUI     = 6'h20;
  localparam logic [5:0] OPTYPE_ALUI_ALT = 6'h28;
  localparam logic [5:0] OPTYPE_ALU      = 6'h30;
  localparam logic [5:0] OPTYPE_ALU_ALT  = 6'h38;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] IC_IDLE    = 2'd0;
  localparam logic [1:0] IC_HOLD    = 2'd1;
  localparam logic [1:0] IC_RECOVER = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = IC_IDLE,
    ST_HOLD    = IC_HOLD,
    ST_RECOVER = IC_RECOVER
  } ic_state_e;

  function automatic logic [5:0] optype_f3(input logic [5:0] base, input logic [2:0] f3);
    return base | {3'b000, f3};
  endfunction

endpackage

// File: rtl/issue_ctrl_dec.sv
// Combinational RV32I-subset decoder: fields, immediate, target class, known-opcode flag.
module issue_ctrl_dec
  import issue_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int OPTYPE_W = 6
) (
  input  logic [XLEN-1:0]     instr,
  output logic                known,
  output logic                is_ls,
  output logic                is_jump,
  output logic [OPTYPE_W-1:0] optype,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [XLEN-1:0]     imm
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic [5:0]  op;
  logic [2:0]  f3;

  assign f3    = instr[14:12];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    op      = OPTYPE_NOP;
    rd      = REG_ZERO;
    rs1     = REG_ZERO;
    rs2     = REG_ZERO;
    imm32   = '0;
    known   = 1'b0;
    is_ls   = 1'b0;
    is_jump = 1'b0;
    case (instr[6:0])
      OPC_LUI:    begin known = 1'b1; op = OPTYPE_LUI;   rd = instr[11:7]; imm32 = imm_u; end
      OPC_AUIPC:  begin known = 1'b1; op = OPTYPE_AUIPC; rd = instr[11:7]; imm32 = imm_u; end
      OPC_JAL:    begin known = 1'b1; op = OPTYPE_JAL; is_jump = 1'b1; rd = instr[11:7]; imm32 = imm_j; end
      OPC_JALR: begin
        known = 1'b1; op = OPTYPE_JALR; is_jump = 1'b1;
        rd = instr[11:7]; rs1 = instr[19:15]; imm32 = imm_i;
      end
      OPC_BRANCH: begin
        known = 1'b1; op = optype_f3(OPTYPE_BRANCH, f3); is_jump = 1'b1;
        rs1 = instr[19:15]; rs2 = instr[24:20]; imm32 = imm_b;
      end
      OPC_LOAD: begin
        known = 1'b1; op = optype_f3(OPTYPE_LOAD, f3); is_ls = 1'b1;
        rd = instr[11:7]; rs1 = instr[19:15]; imm32 = imm_i;
      end
      OPC_STORE: begin
        known = 1'b1; op = optype_f3(OPTYPE_STORE, f3); is_ls = 1'b1;
        rs1 = instr[19:15]; rs2 = instr[24:20]; imm32 = imm_s;
      end
      OPC_ALUI: begin
        // Only the right shift uses bit 30 to select its arithmetic variant.
        known = 1'b1;
        op = optype_f3((f3 == 3'd5 && instr[30]) ? OPTYPE_ALUI_ALT : OPTYPE_ALUI, f3);
        rd = instr[11:7]; rs1 = instr[19:15]; imm32 = imm_i;
      end
      OPC_ALU: begin
        known = 1'b1;
        op = optype_f3(instr[30] ? OPTYPE_ALU_ALT : OPTYPE_ALU, f3);
        rd = instr[11:7]; rs1 = instr[19:15]; rs2 = instr[24:20];
      end
      default: ;
    endcase
  end

  assign optype = OPTYPE_W'(op);
  assign imm    = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/issue_ctrl.sv
// Single-entry issue stage: hold register, decode, ROB alloc and RS/LSB dispatch.
// Queue-to-issue latency 1 cycle; full ROB/target stalls the hold, flush forces a recover cycle.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ROB_IDX_W = 4,
  parameter int OPTYPE_W  = 6,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 iq_valid,
  input  logic [XLEN-1:0]      iq_instr,
  input  logic [XLEN-1:0]      iq_pc,
  output logic                 iq_ready,
  input  logic                 rob_full,
  input  logic [ROB_IDX_W-1:0] rob_tail,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  output logic                 rob_alloc,
  output logic                 rs_issue,
  output logic                 lsb_issue,
  output logic                 is_jump_o,
  output logic [OPTYPE_W-1:0]  optype_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [XLEN-1:0]      imm_o,
  output logic [XLEN-1:0]      pc_o,
  output logic [ROB_IDX_W-1:0] tag_o,
  output logic [CNT_W-1:0]     issue_cnt,
  output logic [CNT_W-1:0]     stall_cnt
);

  ic_state_e             state, state_nxt;
  logic [XLEN-1:0]       hold_instr, hold_pc;
  logic                  dec_known, dec_ls, dec_jump;
  logic [OPTYPE_W-1:0]   dec_optype;
  logic [4:0]            dec_rd, dec_rs1, dec_rs2;
  logic [XLEN-1:0]       dec_imm;
  logic                  busy, can_issue, drop, stall, load;

  issue_ctrl_dec #(.XLEN(XLEN), .OPTYPE_W(OPTYPE_W)) u_dec (
    .instr   (hold_instr),
    .known   (dec_known),
    .is_ls   (dec_ls),
    .is_jump (dec_jump),
    .optype  (dec_optype),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .imm     (dec_imm)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    busy      = (state == ST_HOLD) && dec_known && !flush;
    can_issue = busy && !rob_full && !(dec_ls ? lsb_full : rs_full);
    stall     = busy && !can_issue;
    drop      = (state == ST_HOLD) && !dec_known && !flush;
    // rst_n gates ready so the queue sees no handshake while reset is held.
    iq_ready  = rst_n && !flush && ((state == ST_IDLE) || can_issue || drop);
    load      = iq_valid && iq_ready;

    state_nxt = state;
    if (flush)                     state_nxt = ST_RECOVER;
    else if (state == ST_RECOVER)  state_nxt = ST_IDLE;
    else if (load)                 state_nxt = ST_HOLD;
    else if (can_issue || drop)    state_nxt = ST_IDLE;

    rob_alloc = can_issue;
    rs_issue  = can_issue && !dec_ls;
    lsb_issue = can_issue && dec_ls;
    is_jump_o = can_issue && dec_jump;
    optype_o  = can_issue ? dec_optype : '0;
    rd_o      = can_issue ? dec_rd     : REG_ZERO;
    rs1_o     = can_issue ? dec_rs1    : REG_ZERO;
    rs2_o     = can_issue ? dec_rs2    : REG_ZERO;
    imm_o     = can_issue ? dec_imm    : '0;
    pc_o      = can_issue ? hold_pc    : '0;
    tag_o     = can_issue ? rob_tail   : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_instr <= '0;
      hold_pc    <= '0;
      issue_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      if (load) begin
        hold_instr <= iq_instr;
        hold_pc    <= iq_pc;
      end
      if (can_issue) issue_cnt <= issue_cnt + CNT_W'(1);
      if (stall)     stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed plan plus randomized traffic against a behavioural issue model.
module tb_issue_ctrl;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0080A103;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_BEQ  = 32'h00208863;
  localparam logic [31:0] I_SW   = 32'h0020A623;
  localparam logic [31:0] I_UNK  = 32'h0000000B;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, iq_valid = 1'b0;
  logic [31:0] iq_instr = '0, iq_pc = '0;
  logic        rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
  logic [3:0]  rob_tail = '0;
  logic        iq_ready, rob_alloc, rs_issue, lsb_issue, is_jump_o;
  logic [5:0]  optype_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [31:0] imm_o, pc_o, issue_cnt, stall_cnt;
  logic [3:0]  tag_o;

  issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .iq_valid(iq_valid), .iq_instr(iq_instr),
    .iq_pc(iq_pc), .iq_ready(iq_ready), .rob_full(rob_full), .rob_tail(rob_tail),
    .rs_full(rs_full), .lsb_full(lsb_full), .rob_alloc(rob_alloc), .rs_issue(rs_issue),
    .lsb_issue(lsb_issue), .is_jump_o(is_jump_o), .optype_o(optype_o), .rd_o(rd_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o), .pc_o(pc_o), .tag_o(tag_o),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic known, ls, jmp;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } dec_t;

  // Architectural RV32I field meanings, written straight from the ISA formats.
  function automatic dec_t ref_dec(input logic [31:0] x);
    dec_t d = '0;
    logic [2:0] f3 = x[14:12];
    logic signed [31:0] ii = $signed(x[31:20]);
    logic signed [31:0] is = $signed({x[31:25], x[11:7]});
    logic signed [31:0] ib = $signed({x[31], x[7], x[30:25], x[11:8], 1'b0});
    logic signed [31:0] ij = $signed({x[31], x[19:12], x[20], x[30:21], 1'b0});
    d.known = 1'b1;
    case (x[6:0])
      7'h37: begin d.op = 6'd1; d.rd = x[11:7]; d.imm = {x[31:12], 12'h000}; end
      7'h17: begin d.op = 6'd2; d.rd = x[11:7]; d.imm = {x[31:12], 12'h000}; end
      7'h6F: begin d.op = 6'd3; d.jmp = 1; d.rd = x[11:7]; d.imm = ij; end
      7'h67: begin d.op = 6'd4; d.jmp = 1; d.rd = x[11:7]; d.rs1 = x[19:15]; d.imm = ii; end
      7'h63: begin d.op = 6'd8 + 6'(f3); d.jmp = 1; d.rs1 = x[19:15]; d.rs2 = x[24:20]; d.imm = ib; end
      7'h03: begin d.op = 6'd16 + 6'(f3); d.ls = 1; d.rd = x[11:7]; d.rs1 = x[19:15]; d.imm = ii; end
      7'h23: begin d.op = 6'd24 + 6'(f3); d.ls = 1; d.rs1 = x[19:15]; d.rs2 = x[24:20]; d.imm = is; end
      7'h13: begin
        d.op = 6'd32 + 6'(f3) + ((f3 == 3'd5 && x[30]) ? 6'd8 : 6'd0);
        d.rd = x[11:7]; d.rs1 = x[19:15]; d.imm = ii;
      end
      7'h33: begin
        d.op = 6'd48 + 6'(f3) + (x[30] ? 6'd8 : 6'd0);
        d.rd = x[11:7]; d.rs1 = x[19:15]; d.rs2 = x[24:20];
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // Model: an optional held instruction, a recovery flag and two counters.
  bit          m_have = 0, m_rec = 0;
  logic [31:0] m_instr = '0, m_pc = '0, m_icnt = '0, m_scnt = '0;
  bit          e_issue, e_drop, e_stall, e_ready;

  task automatic compare();
    dec_t d = ref_dec(m_instr);
    bit blocked = rob_full || (d.ls ? lsb_full : rs_full);
    if (!rst_n) begin
      e_issue = 0; e_drop = 0; e_stall = 0; e_ready = 0;
    end else begin
      e_issue = m_have && d.known && !blocked && !flush;
      e_drop  = m_have && !d.known && !flush;
      e_stall = m_have && d.known && blocked && !flush;
      e_ready = !flush && !m_rec && (!m_have || e_issue || e_drop);
    end
    chk("iq_ready",  iq_ready,  e_ready);
    chk("rob_alloc", rob_alloc, e_issue);
    chk("rs_issue",  rs_issue,  e_issue && !d.ls);
    chk("lsb_issue", lsb_issue, e_issue && d.ls);
    chk("is_jump",   is_jump_o, e_issue && d.jmp);
    chk("optype",    optype_o,  e_issue ? d.op  : 6'd0);
    chk("rd",        rd_o,      e_issue ? d.rd  : 5'd0);
    chk("rs1",       rs1_o,     e_issue ? d.rs1 : 5'd0);
    chk("rs2",       rs2_o,     e_issue ? d.rs2 : 5'd0);
    chk("imm",       imm_o,     e_issue ? d.imm : 32'd0);
    chk("pc",        pc_o,      e_issue ? m_pc  : 32'd0);
    chk("tag",       tag_o,     e_issue ? rob_tail : 4'd0);
    chk("issue_cnt", issue_cnt, rst_n ? m_icnt : 32'd0);
    chk("stall_cnt", stall_cnt, rst_n ? m_scnt : 32'd0);
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rf, input logic [3:0] tail, input bit rsf, input bit lsbf,
                       input bit fl);
    iq_valid = v; iq_instr = ins; iq_pc = pc; rob_full = rf; rob_tail = tail;
    rs_full = rsf; lsb_full = lsbf; flush = fl;
    #2;
    compare();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (flush) begin m_have = 0; m_rec = 1; end
      else if (m_rec) m_rec = 0;
      else if (iq_valid && e_ready) begin m_have = 1; m_instr = iq_instr; m_pc = iq_pc; end
      else if (e_issue || e_drop) m_have = 0;
      m_icnt += 32'(e_issue);
      m_scnt += 32'(e_stall);
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0B};
    logic [31:0] r = $urandom();
    return {r[31:7], opc[$urandom_range(0, 9)]};
  endfunction

  initial begin
    #1 compare();
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    drive(1, I_ADDI, 32'h0, 0, 4'd3, 0, 0, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 4'd3, 0, 0, 0);
    chk("addi_rs", rs_issue, 1); chk("addi_op", optype_o, 6'h20);
    chk("addi_rd", rd_o, 1); chk("addi_imm", imm_o, 5); chk("addi_tag", tag_o, 3);
    tick(); chk("addi_cnt", issue_cnt, 1);

    drive(1, I_LW, 32'h4, 0, 4'd5, 0, 1, 0); tick();
    repeat (3) begin
      drive(1, I_ADD, 32'h8, 0, 4'd5, 0, 1, 0);
      chk("lw_stall_rdy", iq_ready, 0); chk("lw_stall_lsb", lsb_issue, 0); tick();
    end
    drive(0, 32'h0, 32'h0, 0, 4'd5, 0, 0, 0);
    chk("lw_lsb", lsb_issue, 1); chk("lw_rs", rs_issue, 0);
    chk("lw_rd", rd_o, 2); chk("lw_imm", imm_o, 8); chk("lw_pc", pc_o, 4);
    tick(); chk("lw_stall_cnt", stall_cnt, 3);

    for (int i = 0; i < 4; i++) begin
      drive(1, I_ADD, 32'h10 + 32'(4 * i), 0, 4'(i), 0, 0, 0);
      if (i > 0) chk("b2b_rs", rs_issue, 1);
      chk("b2b_rdy", iq_ready, 1); tick();
    end
    drive(0, 32'h0, 32'h0, 0, 4'd4, 0, 0, 0); chk("b2b_last", rs_issue, 1);
    tick(); chk("b2b_cnt", issue_cnt, 6);

    drive(1, I_BEQ, 32'h40, 0, 4'd7, 0, 0, 0); tick();
    drive(0, 32'h0, 32'h0, 1, 4'd7, 0, 0, 0); chk("beq_robfull", rob_alloc, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 4'd7, 0, 0, 0);
    chk("beq_rs", rs_issue, 1); chk("beq_jump", is_jump_o, 1);
    chk("beq_rd", rd_o, 0); chk("beq_imm", imm_o, 16); tick();

    drive(1, I_SW, 32'h50, 0, 4'd8, 0, 0, 0); tick();
    drive(1, I_ADD, 32'h54, 0, 4'd8, 0, 0, 1);
    chk("flush_lsb", lsb_issue, 0); chk("flush_rdy", iq_ready, 0); tick();
    drive(1, I_ADD, 32'h54, 0, 4'd8, 0, 0, 0); chk("recover_rdy", iq_ready, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 4'd8, 0, 0, 0); chk("idle_rdy", iq_ready, 1); tick();
    chk("flush_cnt", issue_cnt, 7);

    drive(1, I_UNK, 32'h60, 0, 4'd9, 0, 0, 0); tick();
    drive(1, I_ADDI, 32'h64, 0, 4'd9, 0, 0, 0);
    chk("unk_alloc", rob_alloc, 0); chk("unk_rdy", iq_ready, 1); tick();
    drive(0, 32'h0, 32'h0, 0, 4'd9, 0, 0, 0); chk("unk_next_rs", rs_issue, 1); tick();
    chk("unk_cnt", issue_cnt, 8);

    drive(1, I_LW, 32'h70, 0, 4'd1, 0, 1, 0); tick();
    drive(1, I_ADD, 32'h74, 0, 4'd1, 0, 1, 0);
    #1 rst_n = 1'b0;
    #1 compare();
    chk("rst_stall_cnt", stall_cnt, 0); chk("rst_rdy", iq_ready, 0);
    m_have = 0; m_rec = 0; m_icnt = '0; m_scnt = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom(), $urandom_range(0, 3) == 0,
            4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 19) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Single-stage issue controller between the instruction queue and the out-of-order back end.
- Latches one fetched instruction and decodes it through the team's decoder as a sub-instance.
- Allocates a ROB entry and dispatches the decoded fields to the ALU reservation station (RS) or the load/store buffer (LSB).
- Sequences stalls on full back-end structures and recovers from mispredict flushes; keeps issue and stall counters for debug.

Parameters:
- XLEN, 32, data/instruction/PC width
- ROB_IDX_W, 4, ROB tag width
- OPTYPE_W, 6, width of the decoded operation code
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  mispredict flush from ROB; synchronous in effect
- iq_valid  in  1  instruction queue has an entry
- iq_instr  in  XLEN  raw instruction
- iq_pc  in  XLEN  PC of the instruction
- iq_ready  out  1  controller takes the entry this cycle
- rob_full  in  1  no free ROB entry
- rob_tail  in  ROB_IDX_W  tag that will be allocated
- rs_full  in  1  RS has no free slot
- lsb_full  in  1  LSB has no free slot
- rob_alloc  out  1  allocate ROB entry this cycle
- rs_issue  out  1  write RS this cycle
- lsb_issue  out  1  write LSB this cycle
- is_jump_o  out  1  issued instruction is JAL/JALR/branch
- optype_o  out  OPTYPE_W  decoded operation
- rd_o, rs1_o, rs2_o  out  5 each  register indices
- imm_o  out  XLEN  decoded immediate
- pc_o  out  XLEN  PC of the issued instruction
- tag_o  out  ROB_IDX_W  ROB tag (equals rob_tail when issuing)
- issue_cnt  out  CNT_W  instructions issued since reset
- stall_cnt  out  CNT_W  cycles the hold register was valid but blocked

Behaviour:
- Hold register: hold_valid, hold_instr, hold_pc. The decoder is combinational on hold_instr; all issue outputs are driven from it combinationally, gated by the issue strobes.
- FSM states:
  - IDLE: hold empty.
  - HOLD: hold valid.
  - RECOVER: one cycle after a flush; iq_ready=0.
- Reset (async, rst_n=0): state=IDLE, hold_valid=0, hold_instr=0, hold_pc=0, both counters=0. All strobes and iq_ready deassert immediately and combinationally.
- Target selection: is_ls=1 selects LSB; every other valid opcode selects RS.
- can_issue = HOLD & !rob_full & !(target full).
- On can_issue:
  - rob_alloc=1 plus exactly one of rs_issue/lsb_issue.
  - tag_o=rob_tail; issue_cnt increments by 1, wrapping at 2^CNT_W.
- In HOLD with !can_issue:
  - No strobes; stall_cnt increments by 1, wrapping.
  - The held instruction stays stable with no re-decode glitches.
- Unknown opcode (not one of LUI, AUIPC, JAL, JALR, B, L, A, R, S):
  - Dropped with no strobes and no issue_cnt increment.
  - The hold register empties in that cycle, so it is consumed like an issue.
- iq_ready = (state==IDLE) | (state==HOLD & (can_issue | unknown opcode)); forced 0 in RECOVER or when flush=1.
- iq_valid & iq_ready loads the hold register at the clock edge; next state is HOLD. Back-to-back throughput is 1 instruction/cycle; latency from queue to issue is 1 cycle.
- Issue without a new load: next state is IDLE.
- flush=1 (highest priority over issue and load):
  - All strobes forced 0 that cycle; hold_valid cleared; next state RECOVER.
  - Counters keep their values.
- RECOVER always goes to IDLE the next cycle. A flush arriving during RECOVER stays in RECOVER one more cycle.
- Simultaneous rob_full and target not full: no issue (ROB has priority in the block condition).
- Branches drive rd_o=0; outputs other than strobes are don't-care when no strobe is asserted. They must still be deterministic (no X) after reset.

Decomposition:
- Shared constants header (existing const include) holds:
  - opcode constants, OPTYPE_* encodings, REG_ZERO
  - new localparams IC_IDLE=2'd0, IC_HOLD=2'd1, IC_RECOVER=2'd2
- One sub-module: the existing decoder, instantiated once on hold_instr.
- Counters and FSM live in issue_ctrl itself.

Test Plan:
- Reset then iq_valid with ADDI x1,x0,5 (0x00500093), pc=0x0: next cycle rs_issue=1, rob_alloc=1, optype=ADDI, rd_o=1, imm_o=5, tag_o=rob_tail, issue_cnt=1.
- Stream LW x2,8(x1) (0x0080A103) with lsb_full=1 for 3 cycles, then 0: lsb_issue only on cycle 4, stall_cnt=3, iq_ready=0 during the stall, instruction unchanged.
- Four back-to-back ADDs with no back-pressure: one rs_issue per cycle, iq_ready held 1, issue_cnt=4.
- rob_full=1 with rs_full=0 on BEQ: no strobes; releasing rob_full issues BEQ with rd_o=0 and is_jump_o=1.
- flush in the same cycle as a can_issue SW: no strobes; next cycle state RECOVER with iq_ready=0; the cycle after, IDLE with iq_ready=1; issue_cnt unchanged.
- Opcode 0x0000000B (unknown) followed by ADDI: no strobe for the first; ADDI issues one cycle later; issue_cnt=1. Also assert rst_n low mid-stall: all outputs 0 immediately.
